// File: rtl/pipe_pkg.sv
// Shared IF-stage pipeline types: machine width, PC step, reset PC and the BTB entry layout.
package pipe_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned PC_STEP   = 4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  // Widest tag any legal ENTRIES can produce (ENTRIES = 1); narrower tags are zero-extended.
  localparam int unsigned TAG_MAX_W = XLEN - 2;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [XLEN-1:0]      target;
  } btb_entry_t;

  // Sequential fetch address, 32-bit modulo.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(PC_STEP);
  endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage with one lookup port and one write port.
// Optional same-cycle write-to-lookup bypass when BTB_FWD_EN is defined.
module btb_table
  import pipe_pkg::*;
#(
  parameter int unsigned ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [XLEN-1:0] lookup_pc,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  input  logic [XLEN-1:0] wr_target,
  output logic            hit,
  output logic [XLEN-1:0] target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];

  logic [IDX_W-1:0] lk_idx, wr_idx;
  logic [TAG_W-1:0] lk_tag, wr_tag;
  btb_entry_t       rd;
  logic             unused_lsbs;

  assign lk_idx      = lookup_pc[IDX_W+1:2];
  assign lk_tag      = lookup_pc[XLEN-1:IDX_W+2];
  assign wr_idx      = wr_pc[IDX_W+1:2];
  assign wr_tag      = wr_pc[XLEN-1:IDX_W+2];
  assign unused_lsbs = ^{lookup_pc[1:0], wr_pc[1:0]};

  // Only the valid bits are reset; tag/target are qualified by valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= wr_target;
    end
  end

  // Read the addressed entry; a matching in-flight write may replace it.
  always_comb begin
    rd        = '0;
    rd.valid  = valid[lk_idx];
    rd.tag    = TAG_MAX_W'(tag_mem[lk_idx]);
    rd.target = tgt_mem[lk_idx];
`ifdef BTB_FWD_EN
    if (wr_en && (wr_idx == lk_idx) && (wr_tag == lk_tag)) begin
      rd.valid  = 1'b1;
      rd.tag    = TAG_MAX_W'(wr_tag);
      rd.target = wr_target;
    end
`endif
  end

  assign hit    = rd.valid && (rd.tag == TAG_MAX_W'(lk_tag));
  assign target = rd.target;

endmodule

// File: rtl/btb_npc.sv
// IF-stage next-PC unit: BTB lookup, branch resolution/redirect and branch statistics.
// Build option: define BTB_FWD_EN to let a same-cycle EX write hit the current lookup.
module btb_npc
  import pipe_pkg::*;
#(
  parameter int unsigned     ENTRIES  = 64,
  parameter logic [XLEN-1:0] RESET_PC = pipe_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            stall_if,
  input  logic            jump_global_if,
  input  logic            br_valid_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic            jump_ex,
  input  logic [XLEN-1:0] target_ex,
  input  logic            pred_taken_ex,
  input  logic [XLEN-1:0] pred_target_ex,
  output logic [XLEN-1:0] pc_if,
  output logic            pred_taken_if,
  output logic [XLEN-1:0] pred_target_if,
  output logic            redirect_ex,
  output logic [XLEN-1:0] br_cnt,
  output logic [XLEN-1:0] miss_cnt
);

  localparam logic [XLEN-1:0] CNT_MAX = '1;

  logic            btb_hit;
  logic [XLEN-1:0] btb_target;
  logic            mispredict;
  logic [XLEN-1:0] npc;

  btb_table #(
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk       (clk),
    .rstn      (rstn),
    .lookup_pc (pc_if),
    .wr_en     (br_valid_ex & jump_ex),
    .wr_pc     (pc_ex),
    .wr_target (target_ex),
    .hit       (btb_hit),
    .target    (btb_target)
  );

  // Prediction and misprediction detection are same-cycle.
  always_comb begin
    pred_taken_if  = btb_hit & jump_global_if;
    pred_target_if = btb_hit ? btb_target : pc_inc(pc_if);
    mispredict     = br_valid_ex &&
                     ((jump_ex != pred_taken_ex) ||
                      (jump_ex && (target_ex != pred_target_ex)));
    redirect_ex    = mispredict;
  end

  // Redirect beats stall, stall beats prediction.
  always_comb begin
    npc = pc_inc(pc_if);
    if (mispredict) begin
      npc = jump_ex ? target_ex : pc_inc(pc_ex);
    end else if (stall_if) begin
      npc = pc_if;
    end else if (pred_taken_if) begin
      npc = pred_target_if;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_if <= RESET_PC;
    end else begin
      pc_if <= npc;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else begin
      if (br_valid_ex && (br_cnt != CNT_MAX)) begin
        br_cnt <= br_cnt + XLEN'(1);
      end
      if (mispredict && (miss_cnt != CNT_MAX)) begin
        miss_cnt <= miss_cnt + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_btb_npc.sv
// Self-checking bench for btb_npc: directed scenarios then random traffic against a behavioural model.
module tb_btb_npc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall_if = 1'b0;
  logic        jump_global_if = 1'b0;
  logic        br_valid_ex = 1'b0;
  logic [31:0] pc_ex = '0;
  logic        jump_ex = 1'b0;
  logic [31:0] target_ex = '0;
  logic        pred_taken_ex = 1'b0;
  logic [31:0] pred_target_ex = '0;
  logic [31:0] pc_if;
  logic        pred_taken_if;
  logic [31:0] pred_target_if;
  logic        redirect_ex;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  btb_npc dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall_if       (stall_if),
    .jump_global_if (jump_global_if),
    .br_valid_ex    (br_valid_ex),
    .pc_ex          (pc_ex),
    .jump_ex        (jump_ex),
    .target_ex      (target_ex),
    .pred_taken_ex  (pred_taken_ex),
    .pred_target_ex (pred_target_ex),
    .pc_if          (pc_if),
    .pred_taken_if  (pred_taken_if),
    .pred_target_if (pred_target_if),
    .redirect_ex    (redirect_ex),
    .br_cnt         (br_cnt),
    .miss_cnt       (miss_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: 64-entry table addressed by word index, tag is pc / 256.
  bit          m_valid [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  logic [31:0] m_pc;
  longint      m_br, m_miss;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    m_pc   = 32'h0;
    m_br   = 0;
    m_miss = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check against the model, advance model and clock.
  task automatic step(input logic st, input logic jg, input logic bv, input logic [31:0] pce,
                      input logic je, input logic [31:0] te, input logic pte, input logic [31:0] ptg);
    int unsigned ri, wi;
    logic [31:0] rt, wt, tg, eptg, nxt;
    logic        hit, ept, mis;
    stall_if = st; jump_global_if = jg; br_valid_ex = bv; pc_ex = pce;
    jump_ex = je; target_ex = te; pred_taken_ex = pte; pred_target_ex = ptg;
    #1;
    ri  = (m_pc / 4) % 64;  rt = m_pc / 256;
    wi  = (pce / 4) % 64;   wt = pce / 256;
    hit = m_valid[ri] && (m_tag[ri] == rt);
    tg  = m_tgt[ri];
`ifdef BTB_FWD_EN
    if (bv && je && (wi == ri) && (wt == rt)) begin
      hit = 1'b1;
      tg  = te;
    end
`endif
    ept  = hit && jg;
    eptg = hit ? tg : m_pc + 32'd4;
    mis  = bv && ((je != pte) || (je && (te != ptg)));
    chk("pc_if", pc_if, m_pc);
    chk("pred_taken_if", 32'(pred_taken_if), 32'(ept));
    chk("pred_target_if", pred_target_if, eptg);
    chk("redirect_ex", 32'(redirect_ex), 32'(mis));
    chk("br_cnt", br_cnt, m_br[31:0]);
    chk("miss_cnt", miss_cnt, m_miss[31:0]);
    if (mis)      nxt = je ? te : pce + 32'd4;
    else if (st)  nxt = m_pc;
    else if (ept) nxt = eptg;
    else          nxt = m_pc + 32'd4;
    if (bv && je) begin
      m_valid[wi] = 1'b1; m_tag[wi] = wt; m_tgt[wi] = te;
    end
    if (bv && m_br < 64'hFFFF_FFFF) m_br++;
    if (mis && m_miss < 64'hFFFF_FFFF) m_miss++;
    m_pc = nxt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic jg);
    step(1'b0, jg, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Mispredicted taken branch from an unrelated PC, used to steer fetch.
  task automatic jump_to(input logic [31:0] dest);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3000, 1'b1, dest, 1'b0, 32'h0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc_if", pc_if, 32'h0);
    chk("rst_pred_taken", 32'(pred_taken_if), 32'h0);
    chk("rst_pred_target", pred_target_if, 32'h4);
    chk("rst_br_cnt", br_cnt, 32'h0);
    rstn = 1'b1;

    // Sequential fetch 0,4,8,12.
    for (int i = 0; i < 4; i++) idle(1'b0);

    // Taken 0x40 -> 0x100 predicted not-taken: redirect and BTB install.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    idle(1'b0);
    jump_to(32'h40);
    idle(1'b1);                                   // hit: 0x40 -> 0x100
    // Predicted-taken 0x40 resolves not-taken: redirect to 0x44, entry kept.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    idle(1'b0);
    jump_to(32'h40);
    idle(1'b1);                                   // still hits 0x100
    // Wrong target: redirect to 0x200, entry updated.
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    jump_to(32'h40);
    idle(1'b1);                                   // now predicts 0x200

    // Redirect overrides stall; then stall alone holds.
    step(1'b1, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h80, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Alias: 0x140 overwrites the 0x40 entry, so 0x40 misses.
    step(1'b0, 1'b0, 1'b1, 32'h140, 1'b1, 32'h500, 1'b1, 32'h500);
    jump_to(32'h40);
    idle(1'b1);
    // Write 0x40 while fetching 0x40 (hit this cycle only with forwarding).
    jump_to(32'h40);
    step(1'b0, 1'b1, 1'b1, 32'h40, 1'b1, 32'h600, 1'b1, 32'h600);
    idle(1'b0);

    // 32-bit wrap of pc+4 on both paths.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    jump_to(32'hFFFF_FFFC);
    idle(1'b0);
    idle(1'b0);

    // Random traffic concentrated on a few aliasing PCs so hits occur.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] pce, te, ptg;
      case ($urandom_range(0, 4))
        0: pce = 32'h40;
        1: pce = 32'h140;
        2: pce = 32'h80;
        3: pce = m_pc;
        default: pce = {$urandom_range(0, 32'h3FF), 2'b00};
      endcase
      te  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      ptg = ($urandom_range(0, 1) == 1) ? te : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           pce, 1'($urandom_range(0, 1)), te, 1'($urandom_range(0, 1)), ptg);
    end

    // Counters pinned at all-ones must stay there.
    force dut.br_cnt = 32'hFFFF_FFFF;
    force dut.miss_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.br_cnt;
    release dut.miss_cnt;
    m_br   = 64'hFFFF_FFFF;
    m_miss = 64'hFFFF_FFFF;
    step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h40, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b1, 32'h80, 1'b0, 32'h0);
    idle(1'b0);

    // Asynchronous reset in the middle of a redirect.
    br_valid_ex = 1'b1; pc_ex = 32'h3000; jump_ex = 1'b1; target_ex = 32'h80;
    pred_taken_ex = 1'b0; stall_if = 1'b0; jump_global_if = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("midrst_pc_if", pc_if, 32'h0);
    chk("midrst_pred_taken", 32'(pred_taken_if), 32'h0);
    chk("midrst_pred_target", pred_target_if, 32'h4);
    chk("midrst_redirect", 32'(redirect_ex), 32'h1);
    chk("midrst_miss_cnt", miss_cnt, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    idle(1'b1);
    jump_to(32'h40);
    idle(1'b1);                                   // BTB was invalidated
    idle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_npc.md
# btb_npc

Branch target buffer plus next-PC register for the IF stage. Each cycle it looks up the current `pc_if` in a direct-mapped BTB and combines the hit with the direction bit `jump_global_if` from the global-history predictor to choose the next fetch address. It resolves branches arriving from EX, requests a redirect on misprediction and keeps branch and mispredict statistics. It sits between the predictor (upstream, direction) and the instruction memory / IF-ID register (downstream).

## Interface
Parameters:
- `ENTRIES`, 64: BTB entries, power of two; index = `pc[IDX_W+1:2]`, `IDX_W = log2(ENTRIES)`.
- `RESET_PC`, 32'h0000_0000: fetch address after reset.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, all state on rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `stall_if`  in  1  hold `pc_if` (load-use stall).
- `jump_global_if`  in  1  predicted direction for `pc_if`, from the predictor.
- `br_valid_ex`  in  1  EX holds a resolved branch/jal.
- `pc_ex`  in  32  PC of the EX branch.
- `jump_ex`  in  1  branch actually taken.
- `target_ex`  in  32  actual taken target.
- `pred_taken_ex`  in  1  prediction carried down the pipe with this branch.
- `pred_target_ex`  in  32  predicted target carried down the pipe.
- `pc_if`  out  32  current fetch PC (registered).
- `pred_taken_if`  out  1  `btb_hit & jump_global_if`.
- `pred_target_if`  out  32  BTB target on hit, else `pc_if+4`.
- `redirect_ex`  out  1  mispredict; drives `flush_id`/`flush_ex`.
- `br_cnt`  out  32  resolved-branch counter.
- `miss_cnt`  out  32  mispredict counter.

## Operation
- Entry fields: `valid`, `tag = pc[31:IDX_W+2]`, `target[31:0]`.
- Hit: `valid[idx] && tag[idx]==pc_if tag`.
- Mispredict: `br_valid_ex && (jump_ex != pred_taken_ex || (jump_ex && target_ex != pred_target_ex))`.
- Next PC priority:
  1. Mispredict: `jump_ex ? target_ex : pc_ex+4`.
  2. Else `stall_if`: hold `pc_if`.
  3. Else `pred_taken_if`: `pred_target_if`.
  4. Else `pc_if+4`.
- BTB update: on `br_valid_ex && jump_ex`, write `{1, tag(pc_ex), target_ex}` at `idx(pc_ex)`, overwriting any alias. Not-taken resolutions never modify the BTB; direction belongs to the predictor.
- Counters: `br_cnt` increments on `br_valid_ex`; `miss_cnt` increments on mispredict. Both saturate at 32'hFFFF_FFFF.
- All additions are 32-bit modulo: `pc+4` wraps 32'hFFFF_FFFC to 32'h0.

## Timing
- Reset (asynchronous, any cycle, including mid-redirect): `pc_if=RESET_PC`, all `valid=0`, `br_cnt=miss_cnt=0`. Outputs then read `pred_taken_if=0`, `pred_target_if=RESET_PC+4`, and `redirect_ex` as a function of inputs only.
- `pred_taken_if`, `pred_target_if` and `redirect_ex` are combinational in the same cycle. `pc_if` updates on the next edge (1-cycle redirect latency).
- A redirect overrides a simultaneous `stall_if`.
- A BTB write becomes visible to lookups from the next cycle, unless forwarding is enabled (see Configuration).
- A simultaneous write and lookup to different indices are independent.
- `target`/`tag` storage has no reset; only `valid` is reset.

## Configuration
- `BTB_FWD_EN` defined: a same-cycle EX write whose index and tag match `pc_if` forwards `target_ex` as a hit in that cycle.
- `BTB_FWD_EN` undefined: the lookup sees only the stored entry; the write lands at the edge.

## Structure
- Shared package `pipe_pkg`: `XLEN=32`, `PC_STEP=4`, `RESET_PC` default, and a `btb_entry_t` struct `{valid, tag, target}`.
- Sub-module `btb_table`: storage, lookup and write port, with the `BTB_FWD_EN` bypass inside. `btb_npc` holds the PC register, priority mux, mispredict logic and counters.

## Test plan
- Reset with `stall_if=0`, no branches → `pc_if` = 0, 4, 8, 12 on successive cycles; `pred_taken_if=0`.
- EX taken branch `pc_ex=0x40`, `target_ex=0x100`, `pred_taken_ex=0` → `redirect_ex=1`, next `pc_if=0x100`, `miss_cnt=1`. A later fetch of 0x40 with `jump_global_if=1` → `pred_target_if=0x100`, next PC 0x100.
- Predicted-taken 0x40 resolves not-taken → redirect to 0x44; the BTB entry is still valid.
- Taken with `pred_target_ex=0x100`, `target_ex=0x200` → redirect to 0x200; the entry is updated to 0x200.
- `stall_if=1` together with a mispredict to 0x80 → `pc_if=0x80` next cycle. `stall_if=1` alone → `pc_if` held.
- Alias 0x40 vs 0x140 (`ENTRIES=64`): after writing 0x140, a fetch of 0x40 misses. With `BTB_FWD_EN`, writing 0x40 while fetching 0x40 hits the same cycle. Counters at 32'hFFFF_FFFF stay saturated.
